score_keeper: RTL and testbench
===============================

# score_keeper

Game-score sequencer for the Pong design: turns per-player goal events from the ball logic into the 4-bit BCD-range scores `p1_score`/`p2_score` consumed by the seven-segment display block. It also times the serve delay, gates ball motion, and detects game over. It sits between the ball/collision logic and the display decoder, and is the producing end of the score interface.

## Interface
Parameters:
- `WIN_SCORE`, default 9. Score that ends the game. Legal range 1..9, so the display never sees a value above 9.
- `SERVE_DELAY_MS`, default 1000. Number of `clk_1ms` ticks between a serve request and the ball becoming active. Legal range 1..65535.

Ports:
- `clk`, input, 1. System clock.
- `clk_1ms`, input, 1. 1 ms tick, synchronous to `clk`. Each rising edge seen on `clk` counts as one tick.
- `reset`, input, 1. Asynchronous, active-low reset.
- `start`, input, 1. Start/restart button, level, synchronous to `clk`.
- `p1_goal`, input, 1. Level from ball logic: ball crossed player 2's edge, so player 1 scores.
- `p2_goal`, input, 1. Level: player 2 scores.
- `p1_score`, output, 4. Player 1 score, 0..WIN_SCORE.
- `p2_score`, output, 4. Player 2 score, 0..WIN_SCORE.
- `ball_active`, output, 1. High only in PLAY; ball logic moves the ball only while this is high.
- `serve_dir`, output, 1. 0 = serve toward player 1, 1 = toward player 2.
- `game_over`, output, 1. High in OVER.
- `winner`, output, 1. 0 = player 1 won, 1 = player 2 won. Valid only while `game_over` is high.

## Operation
- All of `start`, `p1_goal`, `p2_goal` and `clk_1ms` pass through a rising-edge detector (one history flop). Only the single-cycle edge pulses are used; held levels never re-trigger.
- States are IDLE, SERVE, PLAY and OVER.
  - IDLE: scores are 0. A `start` edge moves to SERVE and clears the delay counter.
  - SERVE: the delay counter increments on each `clk_1ms` edge. When the count reaches SERVE_DELAY_MS, the block moves to PLAY and the counter is cleared.
  - PLAY: a `p1_goal` edge alone increments `p1_score` and sets `serve_dir` to 1 (serve toward the player who conceded). A `p2_goal` edge alone increments `p2_score` and sets `serve_dir` to 0.
    - If the incremented score equals WIN_SCORE, the block moves to OVER. `winner` is set to the scorer and `game_over` is set.
    - Otherwise the block moves to SERVE.
  - OVER: scores and `winner` hold. A `start` edge clears both scores and `game_over`, then moves to SERVE. `serve_dir` is unchanged.
- Simultaneous `p1_goal` and `p2_goal` edges in PLAY: no point is awarded, `serve_dir` is unchanged, and the block moves to SERVE (re-serve).
- Goal edges outside PLAY are ignored.
- `start` edges in SERVE or PLAY are ignored.
- Scores never exceed WIN_SCORE and never wrap.

## Timing
- Reset state: IDLE; `p1_score` = 0, `p2_score` = 0, `ball_active` = 0, `serve_dir` = 0, `game_over` = 0, `winner` = 0; delay counter and edge-history flops cleared.
- Reset asserted mid-game, in any state, forces the reset values immediately (asynchronous).
- Goal latency: an input first sampled high at edge N produces a score change at edge N+1. `ball_active` falls on that same edge.
- Serve latency: `ball_active` rises on the clk edge at which the SERVE_DELAY_MS-th `clk_1ms` edge is detected, counting from SERVE entry.
- A `clk_1ms` edge detected in the same cycle as SERVE entry is not counted.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared package `pong_pkg` holds:
  - the state enumeration (IDLE, SERVE, PLAY, OVER);
  - `SCORE_W` = 4;
  - the default WIN_SCORE and SERVE_DELAY_MS constants, which are shared with the display and ball blocks.
- Sub-module `rise_detect`: one flop plus an AND gate. It is instantiated four times, once each for `start`, `p1_goal`, `p2_goal` and `clk_1ms`.
- The delay counter width is sized from SERVE_DELAY_MS, 16 bits maximum.

## Test plan
- Reset, then a `start` pulse, then 1000 `clk_1ms` ticks: `ball_active` is 0 through tick 999 and 1 at tick 1000; scores read 0/0.
- In PLAY, hold `p1_goal` high for 50 cycles: `p1_score` goes 0→1 exactly once, `serve_dir` = 1, and the block is back in SERVE with `ball_active` = 0.
- Drive `p2_goal` to 9 points with WIN_SCORE = 9: `p2_score` = 9, `game_over` = 1, `winner` = 1. Further goal pulses leave the scores unchanged. A `start` pulse clears to 0/0 and enters SERVE.
- `p1_goal` and `p2_goal` edges in the same cycle during PLAY at score 3/4: the score stays 3/4, `serve_dir` is unchanged, and the block enters SERVE.
- Goal pulses during SERVE and a `start` pulse during PLAY: no state or score change.
- Assert `reset` low mid-SERVE at score 5/2: all outputs go to reset values without waiting for a `clk` edge. After release the block stays in IDLE until a `start` pulse.

Source files
------------

// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared Pong types and constants
//
// Holds the game state enumeration, the score width and the default
// win score / serve delay shared by score, display and ball blocks.
package pong_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_PLAY  = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    localparam int SCORE_W            = 4;
    localparam int DEF_WIN_SCORE      = 9;
    localparam int DEF_SERVE_DELAY_MS = 1000;

    // Bits needed to count 0..delay-1, capped at 16.
    function automatic int delay_cnt_width(input int delay);
        int w;
        w = (delay < 2) ? 1 : $clog2(delay);
        return (w > 16) ? 16 : w;
    endfunction

endpackage

// File: rtl/rise_detect.sv
// rtl/rise_detect.sv - single-flop rising-edge detector
//
// Ports:
//   clk   - system clock
//   reset - asynchronous active-low reset, clears the history flop
//   din   - level input, synchronous to clk
//   pulse - high for the one cycle in which din is high and was low
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic pulse
);

    logic hist;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist <= 1'b0;
        end else begin
            hist <= din;
        end
    end

    assign pulse = din & ~hist;

endmodule

// File: rtl/score_keeper.sv
// rtl/score_keeper.sv - Pong score sequencer, serve timer and game-over detect
//
// Ports:
//   clk         - system clock
//   clk_1ms     - 1 ms tick level, synchronous to clk
//   reset       - asynchronous active-low reset
//   start       - start/restart button level
//   p1_goal     - player 1 scores (level from ball logic)
//   p2_goal     - player 2 scores (level from ball logic)
//   p1_score    - player 1 score, 0..WIN_SCORE
//   p2_score    - player 2 score, 0..WIN_SCORE
//   ball_active - high only while the ball is in play
//   serve_dir   - 0 serve toward player 1, 1 toward player 2
//   game_over   - high once a player reaches WIN_SCORE
//   winner      - 0 player 1 won, 1 player 2 won (valid with game_over)
module score_keeper
    import pong_pkg::*;
#(
    parameter int WIN_SCORE      = DEF_WIN_SCORE,
    parameter int SERVE_DELAY_MS = DEF_SERVE_DELAY_MS
) (
    input  logic               clk,
    input  logic               clk_1ms,
    input  logic               reset,
    input  logic               start,
    input  logic               p1_goal,
    input  logic               p2_goal,
    output logic [SCORE_W-1:0] p1_score,
    output logic [SCORE_W-1:0] p2_score,
    output logic               ball_active,
    output logic               serve_dir,
    output logic               game_over,
    output logic               winner
);

    localparam int                 CNT_W     = delay_cnt_width(SERVE_DELAY_MS);
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(SERVE_DELAY_MS - 1);
    localparam logic [SCORE_W-1:0] SCORE_WIN = SCORE_W'(WIN_SCORE);

    logic start_pulse, p1_pulse, p2_pulse, tick_pulse;
    logic start_e, p1_e, p2_e, tick_e;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [SCORE_W-1:0] p1_next, p2_next;

    rise_detect u_rd_start (.clk(clk), .reset(reset), .din(start),   .pulse(start_pulse));
    rise_detect u_rd_p1    (.clk(clk), .reset(reset), .din(p1_goal), .pulse(p1_pulse));
    rise_detect u_rd_p2    (.clk(clk), .reset(reset), .din(p2_goal), .pulse(p2_pulse));
    rise_detect u_rd_tick  (.clk(clk), .reset(reset), .din(clk_1ms), .pulse(tick_pulse));

    // Edge pulses are registered once so the sequencer acts one cycle after
    // an input is first sampled high and no input reaches an output
    // through combinational logic.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            start_e <= 1'b0;
            p1_e    <= 1'b0;
            p2_e    <= 1'b0;
            tick_e  <= 1'b0;
        end else begin
            start_e <= start_pulse;
            p1_e    <= p1_pulse;
            p2_e    <= p2_pulse;
            tick_e  <= tick_pulse;
        end
    end

    assign p1_next = p1_score + SCORE_W'(1);
    assign p2_next = p2_score + SCORE_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            p1_score    <= '0;
            p2_score    <= '0;
            ball_active <= 1'b0;
            serve_dir   <= 1'b0;
            game_over   <= 1'b0;
            winner      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_e) begin
                        state <= ST_SERVE;
                        cnt   <= '0;
                    end
                end

                // A tick arriving in the entry cycle was seen while still in
                // the previous state, so it is naturally not counted.
                ST_SERVE: begin
                    if (tick_e) begin
                        if (cnt == CNT_LAST) begin
                            state       <= ST_PLAY;
                            cnt         <= '0;
                            ball_active <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end

                ST_PLAY: begin
                    if (p1_e && p2_e) begin
                        // Tied goal: no point, same serve direction, re-serve.
                        state       <= ST_SERVE;
                        cnt         <= '0;
                        ball_active <= 1'b0;
                    end else if (p1_e) begin
                        p1_score    <= p1_next;
                        serve_dir   <= 1'b1;
                        cnt         <= '0;
                        ball_active <= 1'b0;
                        if (p1_next == SCORE_WIN) begin
                            state     <= ST_OVER;
                            game_over <= 1'b1;
                            winner    <= 1'b0;
                        end else begin
                            state <= ST_SERVE;
                        end
                    end else if (p2_e) begin
                        p2_score    <= p2_next;
                        serve_dir   <= 1'b0;
                        cnt         <= '0;
                        ball_active <= 1'b0;
                        if (p2_next == SCORE_WIN) begin
                            state     <= ST_OVER;
                            game_over <= 1'b1;
                            winner    <= 1'b1;
                        end else begin
                            state <= ST_SERVE;
                        end
                    end
                end

                ST_OVER: begin
                    if (start_e) begin
                        p1_score  <= '0;
                        p2_score  <= '0;
                        game_over <= 1'b0;
                        cnt       <= '0;
                        state     <= ST_SERVE;
                    end
                end

                default: begin
                    state       <= ST_IDLE;
                    ball_active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_score_keeper.sv
// tb/tb_score_keeper.sv - self-checking bench for score_keeper
module tb_score_keeper;

    localparam int DELAY = 1000;
    localparam int WIN   = 9;

    localparam int M_IDLE  = 0;
    localparam int M_SERVE = 1;
    localparam int M_PLAY  = 2;
    localparam int M_OVER  = 3;

    logic       clk = 1'b0;
    logic       clk_1ms = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       p1_goal = 1'b0;
    logic       p2_goal = 1'b0;
    logic [3:0] p1_score, p2_score;
    logic       ball_active, serve_dir, game_over, winner;

    always #5 clk = ~clk;

    score_keeper dut (
        .clk        (clk),
        .clk_1ms    (clk_1ms),
        .reset      (reset),
        .start      (start),
        .p1_goal    (p1_goal),
        .p2_goal    (p2_goal),
        .p1_score   (p1_score),
        .p2_score   (p2_score),
        .ball_active(ball_active),
        .serve_dir  (serve_dir),
        .game_over  (game_over),
        .winner     (winner)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    int m_mode  = M_IDLE;
    int m_p1    = 0;
    int m_p2    = 0;
    int m_ticks = 0;
    int m_dir   = 0;
    int m_over  = 0;
    int m_win   = 0;

    task automatic check(input string tag, input int got, input int exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: game rules applied per isolated input event.
    task automatic m_reset();
        m_mode = M_IDLE; m_p1 = 0; m_p2 = 0; m_ticks = 0;
        m_dir = 0; m_over = 0; m_win = 0;
    endtask

    task automatic ev_start();
        if (m_mode == M_IDLE || m_mode == M_OVER) begin
            if (m_mode == M_OVER) begin
                m_p1 = 0; m_p2 = 0; m_over = 0;
            end
            m_mode  = M_SERVE;
            m_ticks = 0;
        end
    endtask

    task automatic ev_tick();
        if (m_mode == M_SERVE) begin
            m_ticks++;
            if (m_ticks == DELAY) begin
                m_mode  = M_PLAY;
                m_ticks = 0;
            end
        end
    endtask

    task automatic ev_goal(input bit a, input bit b);
        if (m_mode != M_PLAY || !(a || b)) return;
        m_ticks = 0;
        if (a && b) begin
            m_mode = M_SERVE;
        end else if (a) begin
            m_p1++; m_dir = 1;
            if (m_p1 == WIN) begin m_mode = M_OVER; m_over = 1; m_win = 0; end
            else m_mode = M_SERVE;
        end else begin
            m_p2++; m_dir = 0;
            if (m_p2 == WIN) begin m_mode = M_OVER; m_over = 1; m_win = 1; end
            else m_mode = M_SERVE;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".p1_score"}, int'(p1_score), m_p1);
        check({tag, ".p2_score"}, int'(p2_score), m_p2);
        check({tag, ".ball_active"}, int'(ball_active), (m_mode == M_PLAY) ? 1 : 0);
        check({tag, ".serve_dir"}, int'(serve_dir), m_dir);
        check({tag, ".game_over"}, int'(game_over), m_over);
        if (m_over != 0) check({tag, ".winner"}, int'(winner), m_win);
    endtask

    task automatic start_pulse();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        ev_start();
    endtask

    task automatic tick();
        clk_1ms = 1'b1;
        @(negedge clk);
        clk_1ms = 1'b0;
        @(negedge clk);
        ev_tick();
    endtask

    task automatic goal(input bit a, input bit b, input int hold);
        p1_goal = a;
        p2_goal = b;
        repeat (hold) @(negedge clk);
        p1_goal = 1'b0;
        p2_goal = 1'b0;
        repeat (2) @(negedge clk);
        ev_goal(a, b);
    endtask

    // Runs the remaining serve ticks; ball must stay low until the last one.
    task automatic serve_out(input string tag, input bit noise);
        int left;
        left = DELAY - m_ticks;
        for (int i = 0; i < left; i++) begin
            if (noise && $urandom_range(0, 199) == 0) begin
                if ($urandom_range(0, 1) == 0) goal(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 4));
                else start_pulse();
                check_all({tag, ".noise"});
            end
            tick();
            if (i == left - 1 || i == left - 2 || noise == 0)
                check({tag, ".ball_tick"}, int'(ball_active), (i == left - 1) ? 1 : 0);
        end
        check_all(tag);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int order[$];
        int j, tmp;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset.p1_score", int'(p1_score), 0);
        check("reset.p2_score", int'(p2_score), 0);
        check("reset.ball_active", int'(ball_active), 0);
        check("reset.serve_dir", int'(serve_dir), 0);
        check("reset.game_over", int'(game_over), 0);
        check("reset.winner", int'(winner), 0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_all("idle");

        // Start and full serve delay
        start_pulse();
        check_all("serve_entry");
        serve_out("serve1", 1'b0);

        // Held p1_goal: one point, exact latency
        p1_goal = 1'b1;
        @(negedge clk);
        check("lat.edge_n", int'(p1_score), 0);
        check("lat.edge_n_ball", int'(ball_active), 1);
        @(negedge clk);
        check("lat.edge_n1", int'(p1_score), 1);
        check("lat.edge_n1_ball", int'(ball_active), 0);
        repeat (48) @(negedge clk);
        p1_goal = 1'b0;
        repeat (2) @(negedge clk);
        ev_goal(1'b1, 1'b0);
        check_all("hold_goal");
        check("hold_goal.dir", int'(serve_dir), 1);

        // Goals during SERVE are ignored
        goal(1'b0, 1'b1, 1);
        goal(1'b1, 1'b0, 3);
        goal(1'b1, 1'b1, 2);
        check_all("serve_goals");
        serve_out("serve2", 1'b1);

        // Start during PLAY is ignored
        start_pulse();
        check_all("play_start");

        // Reach 3/4
        foreach (order[k]) order.delete(k);
        order = '{0, 0, 1, 1, 1, 1};
        for (int k = 0; k < 6; k++) begin
            j = $urandom_range(0, 5);
            tmp = order[k]; order[k] = order[j]; order[j] = tmp;
        end
        foreach (order[k]) begin
            goal(order[k] == 0, order[k] == 1, $urandom_range(1, 8));
            check_all("to34");
            serve_out("to34_serve", 1'b1);
        end
        check("at34.p1", int'(p1_score), 3);
        check("at34.p2", int'(p2_score), 4);

        // Simultaneous goals
        tmp = m_dir;
        goal(1'b1, 1'b1, 2);
        check_all("tie");
        check("tie.dir_kept", int'(serve_dir), tmp);
        check("tie.p1", int'(p1_score), 3);
        check("tie.p2", int'(p2_score), 4);
        serve_out("tie_serve", 1'b1);

        // Player 2 wins
        for (int k = 0; k < 5; k++) begin
            goal(1'b0, 1'b1, 1);
            check_all("p2run");
            if (k < 4) serve_out("p2run_serve", 1'b1);
        end
        check("win.p2_score", int'(p2_score), 9);
        check("win.game_over", int'(game_over), 1);
        check("win.winner", int'(winner), 1);
        goal(1'b0, 1'b1, 1);
        goal(1'b1, 1'b0, 1);
        tick();
        check_all("over_goals");
        check("over.p2_hold", int'(p2_score), 9);
        start_pulse();
        check_all("restart");
        check("restart.p2", int'(p2_score), 0);
        check("restart.dir", int'(serve_dir), 0);
        serve_out("restart_serve", 1'b1);

        // Random order to 5/2, then async reset mid-SERVE
        order = '{0, 0, 0, 0, 0, 1, 1};
        for (int k = 0; k < 7; k++) begin
            j = $urandom_range(0, 6);
            tmp = order[k]; order[k] = order[j]; order[j] = tmp;
        end
        foreach (order[k]) begin
            goal(order[k] == 0, order[k] == 1, $urandom_range(1, 5));
            check_all("to52");
            if (k < 6) serve_out("to52_serve", 1'b1);
        end
        repeat ($urandom_range(10, 400)) tick();
        check_all("pre_reset");
        check("pre_reset.p1", int'(p1_score), 5);
        check("pre_reset.p2", int'(p2_score), 2);

        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("async.p1_score", int'(p1_score), 0);
        check("async.p2_score", int'(p2_score), 0);
        check("async.ball_active", int'(ball_active), 0);
        check("async.serve_dir", int'(serve_dir), 0);
        check("async.game_over", int'(game_over), 0);
        check("async.winner", int'(winner), 0);
        m_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Stays idle without a start
        for (int k = 0; k < 5; k++) tick();
        goal(1'b1, 1'b0, 2);
        goal(1'b0, 1'b1, 2);
        check_all("post_reset_idle");

        // Delay counter restarts from zero
        start_pulse();
        serve_out("post_reset_serve", 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
